// File: rtl/red_seq_if.sv
// Port bundle for the RED sequencer: the instruction-issue signals plus the shared-adder port.
// Issue side: start is accepted on a posedge only while busy==0. Adder side: add_req/add_a/add_b stay
// stable until add_gnt is high at a posedge, and that edge consumes add_sum.
interface red_seq_if #(parameter int DATA_W = 16);
  logic              start;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              add_req;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic [DATA_W-1:0] add_sum;
  logic              add_gnt;

  modport master (
    output start, rs, rt, add_sum, add_gnt,
    input  busy, done, result, add_req, add_a, add_b, add_cin
  );

  modport slave (
    input  start, rs, rt, add_sum, add_gnt,
    output busy, done, result, add_req, add_a, add_b, add_cin
  );
endinterface

// File: rtl/red_seq_ctrl.sv
// RED instruction sequencer: sums the four signed bytes of rs and rt using three passes
// through the shared saturating adder (rs bytes, rt bytes, then the two partial sums).
module red_seq_ctrl #(
  parameter int DATA_W  = 16,
  parameter bit USE_GNT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  red_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, P1, P2, P3} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] rs_q, rt_q, ps1, ps2, result_q;
  logic              done_q;
  logic              gnt_seen;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  assign gnt_seen = USE_GNT ? bus.add_gnt : 1'b1;

  // Adder operands are decoded from state and registers only, never from add_gnt.
  always_comb begin
    next_state  = state;
    bus.add_req = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    case (state)
      IDLE: begin
        if (bus.start) next_state = P1;
      end
      P1: begin
        bus.add_req = 1'b1;
        bus.add_a   = sext8(rs_q[15:8]);
        bus.add_b   = sext8(rs_q[7:0]);
        if (gnt_seen) next_state = P2;
      end
      P2: begin
        bus.add_req = 1'b1;
        bus.add_a   = sext8(rt_q[15:8]);
        bus.add_b   = sext8(rt_q[7:0]);
        if (gnt_seen) next_state = P3;
      end
      P3: begin
        bus.add_req = 1'b1;
        bus.add_a   = ps1;
        bus.add_b   = ps2;
        if (gnt_seen) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      ps1      <= '0;
      ps2      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == P3) && gnt_seen;
      if (state == IDLE && bus.start) begin
        rs_q <= bus.rs;
        rt_q <= bus.rt;
      end
      if (state == P1 && gnt_seen) ps1 <= bus.add_sum;
      if (state == P2 && gnt_seen) ps2 <= bus.add_sum;
      // result keeps the previous op's value until this capture.
      if (state == P3 && gnt_seen) result_q <= bus.add_sum;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.add_cin = 1'b0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Self-checking bench for red_seq_ctrl: directed cases plus randomized ops with random
// adder grants, checked through an expected-result queue drained by a done monitor.
module tb_red_seq_ctrl;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  red_seq_if #(.DATA_W(W)) bus();

  red_seq_ctrl #(.DATA_W(W), .USE_GNT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];
  int         exp_cyc_q[$];
  int         stall_lo = -10;
  int         stall_hi = -20;
  bit         rand_gnt = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain signed-byte arithmetic.
  function automatic logic [W-1:0] ref_red(input logic [W-1:0] a, input logic [W-1:0] b);
    byte ah, al, bh, bl;
    int  s;
    ah = a[15:8]; al = a[7:0]; bh = b[15:8]; bl = b[7:0];
    s  = int'(ah) + int'(al) + int'(bh) + int'(bl);
    return s[W-1:0];
  endfunction

  function automatic int sext_byte(input logic [7:0] v);
    byte  sb;
    int   s;
    logic [W-1:0] r;
    sb = v;
    s  = int'(sb);
    r  = s[W-1:0];
    return int'(r);
  endfunction

  // ---------------- shared-adder model (saturating) ----------------
  int sum_i;
  always_comb begin
    sum_i = int'($signed(bus.add_a)) + int'($signed(bus.add_b));
    if (sum_i > 32767) sum_i = 32767;
    else if (sum_i < -32768) sum_i = -32768;
    bus.add_sum = sum_i[W-1:0];
  end

  always @(negedge clk) begin
    if (cyc >= stall_lo && cyc <= stall_hi) bus.add_gnt = 1'b0;
    else if (rand_gnt)                      bus.add_gnt = 1'($urandom_range(0, 1));
    else                                    bus.add_gnt = 1'b1;
  end

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  int           mon_ec;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d actual=done result=%0h expected=no done", cyc, bus.result);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ec = exp_cyc_q.pop_front();
        chk("result", int'(bus.result), int'(mon_e));
        if (mon_ec >= 0) chk("done_cycle", cyc, mon_ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit accepted, input int extra);
    bus.start = 1'b1;
    bus.rs    = a;
    bus.rt    = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rs    = W'($urandom);
    bus.rt    = W'($urandom);
    if (accepted) begin
      exp_q.push_back(ref_red(a, b));
      exp_cyc_q.push_back(extra < 0 ? -1 : cyc + 3 + extra);
      chk("busy_after_accept", int'(bus.busy), 1);
    end else begin
      chk("busy_while_ignored", int'(bus.busy), 1);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < bound) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("wait_done_timeout", int'(seen), 1);
  endtask

  function automatic logic [W-1:0] pick_word();
    logic [7:0] hi, lo;
    logic [7:0] edge_bytes [4];
    edge_bytes[0] = 8'h80; edge_bytes[1] = 8'h7F; edge_bytes[2] = 8'hFF; edge_bytes[3] = 8'h00;
    hi = ($urandom_range(0, 1) == 0) ? edge_bytes[$urandom_range(0, 3)] : 8'($urandom);
    lo = ($urandom_range(0, 1) == 0) ? edge_bytes[$urandom_range(0, 3)] : 8'($urandom);
    return {hi, lo};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    logic [W-1:0] sb;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.rs    = '0;
    bus.rt    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_done",    int'(bus.done),    0);
    chk("rst_result",  int'(bus.result),  0);
    chk("rst_add_req", int'(bus.add_req), 0);
    chk("rst_add_a",   int'(bus.add_a),   0);
    chk("rst_add_b",   int'(bus.add_b),   0);
    chk("rst_add_cin", int'(bus.add_cin), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic op, then extremes.
    issue(16'h0102, 16'h0304, 1'b1, 0);
    wait_idle(20);
    issue(16'h8080, 16'h8080, 1'b1, 0);
    wait_idle(20);
    issue(16'h7F7F, 16'h7F7F, 1'b1, 0);
    wait_idle(20);

    // Five stalled grants in P2: operands held and done delayed by 5.
    sb = 16'h85F3;
    issue(16'h1234, sb, 1'b1, 5);
    stall_lo = cyc + 1;
    stall_hi = cyc + 5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("stall_add_req", int'(bus.add_req), 1);
      chk("stall_add_a",   int'(bus.add_a),   sext_byte(sb[15:8]));
      chk("stall_add_b",   int'(bus.add_b),   sext_byte(sb[7:0]));
    end
    wait_idle(20);
    stall_lo = -10;
    stall_hi = -20;

    // Start while busy is ignored.
    issue(16'h0101, 16'h0203, 1'b1, 0);
    issue(16'h7F7F, 16'h7F7F, 1'b0, 0);
    wait_idle(20);
    repeat (4) @(negedge clk);

    // Back-to-back: start in the done cycle.
    issue(16'h1111, 16'h2222, 1'b1, 0);
    wait_done(20);
    issue(16'h0000, 16'hFFFF, 1'b1, 0);
    wait_idle(20);

    // Reset in P2 aborts the op silently.
    issue(16'h0A0B, 16'h0C0D, 1'b1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy",    int'(bus.busy),    0);
    chk("abort_done",    int'(bus.done),    0);
    chk("abort_result",  int'(bus.result),  0);
    chk("abort_add_req", int'(bus.add_req), 0);
    chk("abort_add_a",   int'(bus.add_a),   0);
    chk("abort_add_b",   int'(bus.add_b),   0);
    repeat (6) @(negedge clk);
    issue(16'h0203, 16'hFEFD, 1'b1, 0);
    wait_idle(20);

    // Randomized ops with random grants.
    rand_gnt = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(pick_word(), pick_word(), 1'b1, -1);
      if ($urandom_range(0, 2) == 0) issue(pick_word(), pick_word(), 1'b0, 0);
      wait_idle(300);
      t0 = $urandom_range(0, 2);
      repeat (t0) @(negedge clk);
    end
    rand_gnt = 1'b0;
    repeat (4) @(negedge clk);

    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
